// File: rtl/neuron_pkg.sv
// Shared types for the neuron training sequencer: bus widths, FSM states and
// the packed training-sample layout held in the sample buffer.
package neuron_pkg;

    localparam int X_W = 7;
    localparam int T_W = 2;
    localparam int N_W = 32;
    localparam int S_W = 2 * X_W + T_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FEED   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // One training sample, stored raw: {x1, x2, t}
    typedef struct packed {
        logic signed [X_W-1:0] x1;
        logic signed [X_W-1:0] x2;
        logic signed [T_W-1:0] t;
    } sample_t;

endpackage

// File: rtl/neuron_training_sequencer_sample_buffer.sv
// Training-set store: DEPTH-entry register array filled in append order,
// with an occupancy count and an asynchronous read port for the feeder.
module sample_buffer
    import neuron_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  sample_t           wr_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output sample_t           rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    sample_t mem [DEPTH];
    logic    do_write;

    assign full     = (count == (ADDR_W+1)'(DEPTH));
    // A flush wins over a write presented in the same cycle
    assign do_write = wr_en && !full && !clear;
    assign rd_data  = mem[rd_idx];

    // Occupancy: flush to empty, otherwise grow by one per accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (do_write) begin
            count <= count + (ADDR_W+1)'(1);
        end
    end

    // Sample storage; contents are meaningful only below count
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[count[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/neuron_training_sequencer.sv
// Drives the two-input neuron through repeated epochs over a buffered
// training set until the neuron converges or the epoch limit is reached.
module neuron_training_sequencer
    import neuron_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = 9,
    parameter int EPOCH_W    = 16,
    parameter int MAX_EPOCHS = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load_valid,
    input  logic [X_W-1:0]     load_x1,
    input  logic [X_W-1:0]     load_x2,
    input  logic [T_W-1:0]     load_t,
    output logic               load_ready,
    output logic [ADDR_W:0]    sample_count,
    input  logic               start,
    output logic               busy,
    output logic               neuron_start,
    output logic [N_W-1:0]     neuron_n,
    output logic [X_W-1:0]     neuron_x1,
    output logic [X_W-1:0]     neuron_x2,
    output logic [T_W-1:0]     neuron_t,
    output logic               neuron_valid,
    input  logic               neuron_ready,
    input  logic               neuron_done,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic               done,
    output logic               timeout,
    output logic               empty_err
);

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   next_idx;
    logic [ADDR_W-1:0]   rd_idx;
    sample_t             rd_sample;
    sample_t             load_sample;
    logic                full;
    logic                last;
    logic                xfer;
    logic                limit_hit;
    logic [EPOCH_W-1:0]  epoch_inc;

    assign load_sample = {load_x1, load_x2, load_t};
    assign load_ready  = (state == IDLE) && !full;
    assign busy        = (state == LAUNCH) || (state == FEED);

    assign last      = ({1'b0, idx} == sample_count - (ADDR_W+1)'(1));
    assign next_idx  = last ? '0 : idx + ADDR_W'(1);
    // The buses are preloaded with the sample that follows the one being
    // transferred, so the read address leads the index by one while feeding
    assign rd_idx    = (state == FEED) ? next_idx : '0;
    assign xfer      = (state == FEED) && neuron_valid && neuron_ready;
    assign epoch_inc = epoch_count + EPOCH_W'(1);
    assign limit_hit = (epoch_inc == EPOCH_W'(MAX_EPOCHS));

    sample_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear && (state == IDLE)),
        .wr_en   (load_valid && load_ready),
        .wr_data (load_sample),
        .rd_idx  (rd_idx),
        .rd_data (rd_sample),
        .count   (sample_count),
        .full    (full)
    );

    // Training FSM: launch, stream samples epoch after epoch, finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            epoch_count  <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            empty_err    <= 1'b0;
            neuron_start <= 1'b0;
            neuron_valid <= 1'b0;
            neuron_n     <= '0;
            neuron_x1    <= '0;
            neuron_x2    <= '0;
            neuron_t     <= '0;
        end else begin
            neuron_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        empty_err   <= 1'b0;
                        epoch_count <= '0;
                        if (sample_count == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            empty_err <= 1'b1;
                        end else begin
                            state        <= LAUNCH;
                            neuron_start <= 1'b1;
                            neuron_n     <= N_W'(sample_count);
                            neuron_x1    <= rd_sample.x1;
                            neuron_x2    <= rd_sample.x2;
                            neuron_t     <= rd_sample.t;
                            idx          <= '0;
                        end
                    end
                end
                LAUNCH: begin
                    if (neuron_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= FEED;
                        neuron_valid <= 1'b1;
                    end
                end
                FEED: begin
                    if (xfer) begin
                        idx       <= next_idx;
                        neuron_x1 <= rd_sample.x1;
                        neuron_x2 <= rd_sample.x2;
                        neuron_t  <= rd_sample.t;
                        if (last) begin
                            epoch_count <= epoch_inc;
                        end
                    end
                    // Convergence takes priority over the epoch limit
                    if (neuron_done) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        neuron_valid <= 1'b0;
                    end else if (xfer && last && limit_hit) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        neuron_valid <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_training_sequencer.md
Name: neuron_training_sequencer

Overview:
- Sequences training of the two-input neuron datapath (NeuronModule).
- Buffers a training set of (x1, x2, t) samples loaded over a valid/ready port.
- On start, launches the neuron with the sample count and streams the buffered samples in order, epoch after epoch, using the neuron's readyToGetData handshake.
- Terminates when the neuron reports done or an epoch limit is hit, and reports the epoch count.

Parameters:
- DEPTH, 512, sample buffer capacity.
- ADDR_W, 9, index width; DEPTH = 2**ADDR_W.
- EPOCH_W, 16, epoch counter width.
- MAX_EPOCHS, 1000, epoch limit before timeout; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous buffer flush; honoured only in IDLE.
- load_valid  in  1  load sample present.
- load_x1  in  7  signed x1 of load sample.
- load_x2  in  7  signed x2 of load sample.
- load_t  in  2  signed target, +1/-1.
- load_ready  out  1  buffer accepts a sample.
- sample_count  out  ADDR_W+1  samples held, 0..DEPTH.
- start  in  1  begin training; level-sampled.
- busy  out  1  training in progress.
- neuron_start  out  1  one-cycle launch pulse to the neuron.
- neuron_n  out  32  sample count to the neuron, zero-extended.
- neuron_x1  out  7  X1Bus.
- neuron_x2  out  7  X2Bus.
- neuron_t  out  2  tBus.
- neuron_valid  out  1  buses hold a valid sample.
- neuron_ready  in  1  readyToGetData.
- neuron_done  in  1  neuron converged.
- epoch_count  out  EPOCH_W  completed full passes.
- done  out  1  sticky; training finished.
- timeout  out  1  sticky; finished by epoch limit.
- empty_err  out  1  sticky; start issued with an empty buffer.

Behaviour:
- Reset (async):
  - state = IDLE, sample_count = 0, read index = 0, epoch_count = 0.
  - done, timeout, empty_err, busy, neuron_start, neuron_valid all 0.
  - neuron_x1, neuron_x2, neuron_t, neuron_n all 0.
  - load_ready rises combinationally after reset releases (IDLE, not full).
- load_ready = (state == IDLE) and (sample_count < DEPTH).
- Load accept: load_valid and load_ready at an edge → sample written at index sample_count, then sample_count increments. When full, load_ready = 0 and extra samples are not written.
- clear in IDLE: sample_count = 0; clear beats a same-cycle load.
- Buffer: register array with asynchronous read.
- IDLE, on start = 1:
  - done, timeout, empty_err and epoch_count are cleared.
  - If sample_count = 0 → DONE with empty_err = 1 and done = 1; neuron_start is not pulsed.
  - Otherwise → LAUNCH.
- LAUNCH (exactly 1 cycle):
  - neuron_start = 1; neuron_n = sample_count.
  - Buses loaded with sample[0]; index = 0.
  - neuron_valid = 1 from the next cycle.
  - → FEED.
- FEED:
  - A transfer occurs at an edge where neuron_valid and neuron_ready are both 1.
  - On transfer, the buses load sample[index+1] in the same edge, so back-to-back transfers run at full rate.
  - When index = sample_count-1, index wraps to 0 (buses load sample[0]) and epoch_count increments.
  - If the incremented epoch_count equals MAX_EPOCHS: → DONE with timeout = 1 and neuron_valid = 0.
  - While neuron_ready = 0, the buses hold steady.
- neuron_done = 1 in LAUNCH or FEED:
  - → DONE; neuron_valid drops the next cycle.
  - A transfer in the same cycle still counts, including its epoch increment.
  - If the epoch limit is reached in the same cycle, done wins and timeout stays 0.
- DONE:
  - done = 1; busy = 0.
  - Returns to IDLE the next cycle; the done, timeout and empty_err flags stay sticky until the next start.
  - Buffer contents are retained, so a retrain needs no reload.
- busy = 1 in LAUNCH and FEED.
- start while busy is ignored.
- rst_n asserted mid-training aborts immediately to reset values; buffer contents are lost (sample_count = 0).
- Widths: samples are stored raw as 16 bits (7+7+2); no arithmetic is applied to the data.

Decomposition:
- Shared package neuron_pkg holds:
  - X_W = 7, T_W = 2, N_W = 32;
  - the state enum {IDLE, LAUNCH, FEED, DONE};
  - a packed sample struct {x1, x2, t}.
- One sub-module is natural: sample_buffer (DEPTH x 16 register array; write port; async read port; count; full). The FSM and epoch logic stay in the top level.

Test Plan:
- Reset then load 5 samples (x1 = 7'b1110000, x2 = 7'b0010000, t = 2'b11, ...) → sample_count = 5; load_ready stays 1.
- Start with neuron_ready held at 1 → neuron_start pulses once with neuron_n = 5; samples appear in order 0..4 then 0 on consecutive cycles; epoch_count = 1 after the 5th transfer.
- Toggle neuron_ready 1/0 every cycle → each sample is held while ready = 0 and none is skipped or duplicated; 10 transfers → epoch_count = 2.
- Assert neuron_done on the 3rd transfer of epoch 2 → done = 1, timeout = 0, epoch_count = 1, neuron_valid = 0 the next cycle.
- MAX_EPOCHS = 3, 2 samples, neuron_done never asserted → timeout = 1 and done = 1 after 6 transfers; epoch_count = 3. Then start with neuron_done on the final transfer → done = 1, timeout = 0.
- Edge cases:
  - start with an empty buffer → empty_err = 1, done = 1, no neuron_start.
  - Fill to DEPTH → load_ready = 0.
  - rst_n low mid-FEED → all outputs at reset values and sample_count = 0.
